// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N up/down counter family.
// Mode encodings and the default count-width helper.
package counter_pkg;

  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/modn_updown_counter_gen_if.sv
// Control/status bundle of one counter digit.
// master drives strobes, slave is the counter.
interface modn_updown_counter_gen_if #(
  parameter int W       = 4,
  parameter int EPOCH_W = 8
);
  logic               clr;
  logic               load;
  logic [W-1:0]       load_val;
  logic               en;
  logic               up;
  logic               sat_mode;
  logic [W-1:0]       count;
  logic [EPOCH_W-1:0] epoch;
  logic               at_max;
  logic               at_min;
  logic               carry;
  logic               borrow;
  logic               sat_hit;
  logic               load_err;
  logic               cascade_out;

  modport master (
    output clr, load, load_val,
    output en, up, sat_mode,
    input  count, epoch,
    input  at_max, at_min,
    input  carry, borrow,
    input  sat_hit, load_err,
    input  cascade_out
  );

  modport slave (
    input  clr, load, load_val,
    input  en, up, sat_mode,
    output count, epoch,
    output at_max, at_min,
    output carry, borrow,
    output sat_hit, load_err,
    output cascade_out
  );
endinterface

// File: rtl/modn_next_val.sv
// Combinational single-step next value for a mod-N counter.
// Works in W+1 bits so N-1+1 never aliases when N == 2^W.
module modn_next_val
  import counter_pkg::*;
#(
  parameter int N = 10,
  parameter int W = cnt_width(N)
) (
  input  logic [W-1:0] count,
  input  logic         up,
  input  logic         sat_mode,
  output logic [W-1:0] nxt,
  output logic         wrap_up,
  output logic         wrap_dn,
  output logic         sat
);

  localparam logic [W:0] MAXV = (W+1)'(N - 1);

  logic [W:0] cnt_x;
  logic [W:0] inc_x;
  logic [W:0] dec_x;
  logic       at_top;
  logic       at_bot;
  logic       is_sat;

  assign cnt_x  = {1'b0, count};
  assign inc_x  = cnt_x + 1'b1;
  assign dec_x  = cnt_x - 1'b1;
  assign at_top = (cnt_x == MAXV);
  assign at_bot = (cnt_x == '0);
  assign is_sat = (sat_mode == CNT_MODE_SAT);

  always_comb begin
    nxt     = count;
    wrap_up = 1'b0;
    wrap_dn = 1'b0;
    sat     = 1'b0;
    unique case (1'b1)
      up && !at_top:
        nxt = inc_x[W-1:0];
      up && at_top && !is_sat: begin
        nxt     = '0;
        wrap_up = 1'b1;
      end
      up && at_top && is_sat:
        sat = 1'b1;
      !up && !at_bot:
        nxt = dec_x[W-1:0];
      !up && at_bot && !is_sat: begin
        nxt     = MAXV[W-1:0];
        wrap_dn = 1'b1;
      end
      !up && at_bot && is_sat:
        sat = 1'b1;
    endcase
  end

endmodule

// File: rtl/modn_updown_counter_gen.sv
// Mod-N up/down counter: load, clear, wrap/saturate,
// carry/borrow pulses and a signed-wrap epoch counter.
module modn_updown_counter_gen
  import counter_pkg::*;
#(
  parameter int N       = 10,
  parameter int W       = cnt_width(N),
  parameter int EPOCH_W = 8
) (
  input logic clk,
  input logic arst,
  modn_updown_counter_gen_if.slave bus
);

  localparam logic [W-1:0] MAXC = W'(N - 1);
  localparam logic [W:0]   NX   = (W+1)'(N);

  logic [W-1:0]       count_q,  count_d;
  logic [EPOCH_W-1:0] epoch_q,  epoch_d;
  logic               carry_q,  carry_d;
  logic               borrow_q, borrow_d;
  logic               sat_q,    sat_d;
  logic               lerr_q,   lerr_d;

  logic [W-1:0] step_val;
  logic         wrap_up;
  logic         wrap_dn;
  logic         step_sat;
  logic         at_max;
  logic         at_min;
  logic         lv_bad;

  modn_next_val #(.N(N), .W(W)) u_next (
    .count    (count_q),
    .up       (bus.up),
    .sat_mode (bus.sat_mode),
    .nxt      (step_val),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .sat      (step_sat)
  );

  assign lv_bad = ({1'b0, bus.load_val} >= NX);

  // clr > load > en > hold; arst is applied in the register block
  always_comb begin
    count_d  = count_q;
    epoch_d  = epoch_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    sat_d    = 1'b0;
    lerr_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = lv_bad ? MAXC : bus.load_val;
      lerr_d  = lv_bad;
    end else if (bus.en) begin
      count_d  = step_val;
      carry_d  = wrap_up;
      borrow_d = wrap_dn;
      sat_d    = step_sat;
      if (wrap_up) epoch_d = epoch_q + 1'b1;
      if (wrap_dn) epoch_d = epoch_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      count_q  <= '0;
      epoch_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      sat_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      epoch_q  <= epoch_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      sat_q    <= sat_d;
      lerr_q   <= lerr_d;
    end
  end

  assign at_max = (count_q == MAXC);
  assign at_min = (count_q == '0);

  assign bus.count       = count_q;
  assign bus.epoch       = epoch_q;
  assign bus.at_max      = at_max;
  assign bus.at_min      = at_min;
  assign bus.carry       = carry_q;
  assign bus.borrow      = borrow_q;
  assign bus.sat_hit     = sat_q;
  assign bus.load_err    = lerr_q;
  assign bus.cascade_out = bus.en & (bus.up ? at_max : at_min)
                         & ~bus.sat_mode;

endmodule

// File: tb/tb_modn_updown_counter_gen.sv
// Bench: N=10 digit, cascaded N=10 high digit and N=16 counter
// against an arithmetic reference model, directed then random.
module tb_modn_updown_counter_gen;

  logic       clk = 1'b0;
  logic       arst;
  logic       clr, load, en, up, sat;
  logic [3:0] lv;

  int n_cmp = 0;
  int n_bad = 0;

  int nn[3] = '{10, 10, 16};
  int mc[3];
  int me[3];
  bit mca[3], mbo[3], msh[3], mle[3];
  bit m_casc;

  always #5 clk = ~clk;

  modn_updown_counter_gen_if #(.W(4), .EPOCH_W(8)) if0 ();
  modn_updown_counter_gen_if #(.W(4), .EPOCH_W(8)) if1 ();
  modn_updown_counter_gen_if #(.W(4), .EPOCH_W(8)) if2 ();

  assign if0.clr = clr;  assign if0.load = load;
  assign if0.load_val = lv; assign if0.en = en;
  assign if0.up = up;    assign if0.sat_mode = sat;

  assign if1.clr = 1'b0; assign if1.load = 1'b0;
  assign if1.load_val = 4'd0; assign if1.en = if0.cascade_out;
  assign if1.up = up;    assign if1.sat_mode = sat;

  assign if2.clr = clr;  assign if2.load = load;
  assign if2.load_val = lv; assign if2.en = en;
  assign if2.up = up;    assign if2.sat_mode = sat;

  modn_updown_counter_gen #(.N(10), .W(4), .EPOCH_W(8)) u_lo (
    .clk(clk), .arst(arst), .bus(if0.slave));
  modn_updown_counter_gen #(.N(10), .W(4), .EPOCH_W(8)) u_hi (
    .clk(clk), .arst(arst), .bus(if1.slave));
  modn_updown_counter_gen #(.N(16), .W(4), .EPOCH_W(8)) u_16 (
    .clk(clk), .arst(arst), .bus(if2.slave));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void mstep(
    input int n, input bit rs, cl, ld, input int v,
    input bit e, u, s, inout int c, inout int ep,
    output bit ca, bo, sh, le);
    ca = 0; bo = 0; sh = 0; le = 0;
    if (rs) begin
      c = 0; ep = 0;
    end else if (cl) begin
      c = 0;
    end else if (ld) begin
      if (v < n) c = v;
      else begin c = n - 1; le = 1; end
    end else if (e) begin
      if (u) begin
        if (c < n - 1) c = c + 1;
        else if (s) sh = 1;
        else begin c = 0; ca = 1; ep = (ep + 1) % 256; end
      end else begin
        if (c > 0) c = c - 1;
        else if (s) sh = 1;
        else begin c = n - 1; bo = 1; ep = (ep + 255) % 256; end
      end
    end
  endfunction

  function automatic bit casc(input int n, input int c);
    return en && (up ? (c == n - 1) : (c == 0)) && !sat;
  endfunction

  task automatic chk_dut(input string nm, input int i,
    input logic [3:0] c, input logic [7:0] e,
    input logic ca, bo, sh, le, amx, amn);
    chk({nm, "_count"},  c,   mc[i]);
    chk({nm, "_epoch"},  e,   me[i]);
    chk({nm, "_carry"},  ca,  mca[i]);
    chk({nm, "_borrow"}, bo,  mbo[i]);
    chk({nm, "_sathit"}, sh,  msh[i]);
    chk({nm, "_lderr"},  le,  mle[i]);
    chk({nm, "_atmax"},  amx, mc[i] == nn[i] - 1);
    chk({nm, "_atmin"},  amn, mc[i] == 0);
  endtask

  task automatic tick();
    bit hen;
    int c, e;
    hen = casc(10, mc[0]);
    for (int i = 0; i < 3; i++) begin
      c = mc[i]; e = me[i];
      if (i == 1)
        mstep(nn[i], arst, 1'b0, 1'b0, 0, hen, up, sat,
              c, e, mca[i], mbo[i], msh[i], mle[i]);
      else
        mstep(nn[i], arst, clr, load, int'(lv), en, up, sat,
              c, e, mca[i], mbo[i], msh[i], mle[i]);
      mc[i] = c; me[i] = e;
    end
    @(posedge clk);
    #1;
    chk_dut("lo", 0, if0.count, if0.epoch, if0.carry, if0.borrow,
            if0.sat_hit, if0.load_err, if0.at_max, if0.at_min);
    chk_dut("hi", 1, if1.count, if1.epoch, if1.carry, if1.borrow,
            if1.sat_hit, if1.load_err, if1.at_max, if1.at_min);
    chk_dut("n16", 2, if2.count, if2.epoch, if2.carry, if2.borrow,
            if2.sat_hit, if2.load_err, if2.at_max, if2.at_min);
    chk("lo_casc", if0.cascade_out, casc(10, mc[0]));
  endtask

  task automatic idle();
    arst = 0; clr = 0; load = 0; en = 0; up = 1; sat = 0; lv = 0;
  endtask

  task automatic do_reset();
    idle(); arst = 1; tick(); arst = 0;
  endtask

  int hic;

  initial begin
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; me[i] = 0;
    end
    idle();
    arst = 1;
    tick();
    chk("rst_count", if0.count, 0);
    chk("rst_epoch", if0.epoch, 0);
    arst = 0;

    // up through the wrap
    en = 1; up = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t1_count", if0.count, (i + 1) % 10);
      chk("t1_carry", if0.carry, i == 9);
    end
    chk("t1_epoch", if0.epoch, 1);

    // down from 0 in wrap mode
    do_reset();
    en = 1; up = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_count", if0.count, 9 - i);
      chk("t2_borrow", if0.borrow, i == 0);
    end
    chk("t2_epoch", if0.epoch, 255);

    // saturate at the top
    do_reset();
    sat = 1; load = 1; lv = 8;
    tick();
    chk("t3_load", if0.count, 8);
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_count", if0.count, 9);
      chk("t3_sathit", if0.sat_hit, i >= 1);
      chk("t3_carry", if0.carry, 0);
    end

    // out-of-range load, then load beats en
    do_reset();
    load = 1; lv = 13;
    tick();
    chk("t4_count", if0.count, 9);
    chk("t4_lderr", if0.load_err, 1);
    chk("t4_epoch", if0.epoch, 0);
    en = 1; lv = 4;
    tick();
    chk("t4_ld_en", if0.count, 4);
    chk("t4_lderr_gone", if0.load_err, 0);
    idle();
    tick();
    chk("t4_hold", if0.count, 4);

    // clr beats load and keeps epoch
    do_reset();
    en = 1; up = 0;
    tick();
    en = 0; clr = 1; load = 1; lv = 13;
    tick();
    chk("clr_count", if0.count, 0);
    chk("clr_lderr", if0.load_err, 0);
    chk("clr_epoch", if0.epoch, 255);

    // two-digit cascade 00..99..00
    do_reset();
    en = 1; up = 1;
    hic = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (if1.carry) hic++;
      if (i == 98) begin
        chk("t5_lo99", if0.count, 9);
        chk("t5_hi99", if1.count, 9);
      end
    end
    chk("t5_lo00", if0.count, 0);
    chk("t5_hi00", if1.count, 0);
    chk("t5_hicarry", hic, 1);

    // reset mid-count at the top
    do_reset();
    load = 1; lv = 9;
    tick();
    load = 0; en = 1; up = 1; arst = 1;
    tick();
    chk("t6_count", if0.count, 0);
    chk("t6_carry", if0.carry, 0);
    chk("t6_epoch", if0.epoch, 0);

    // N=16 full-width wrap
    do_reset();
    en = 1; up = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t7_count", if2.count, (i + 1) % 16);
      chk("t7_carry", if2.carry, i == 15);
    end

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      arst = ($urandom_range(0, 49) == 0);
      clr  = ($urandom_range(0, 24) == 0);
      load = ($urandom_range(0, 9) == 0);
      lv   = 4'($urandom_range(0, 15));
      en   = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 2) != 0);
      sat  = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/modn_updown_counter_gen.md
# modn_updown_counter_gen

Parametrised up/down modulo-N counter with enable, synchronous parallel load, runtime wrap/saturate mode, carry/borrow pulses and a signed-wrap epoch counter. It is the next generation of the team's mod-N up/down counter. It serves as the standard programmable counting element for timers, ring-index generators and cascaded multi-digit counters in the design.

## Interface
- `N`, 10: modulus; legal range N ≥ 2; count takes values 0..N-1.
- `W`, $clog2(N): count width; must satisfy 2^W ≥ N.
- `EPOCH_W`, 8: epoch counter width.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `arst` input, 1 bit: reset, **synchronous, active-high**, sampled on `clk`.
- `clr` input, 1 bit: synchronous clear of `count` only; `epoch` is kept.
- `load` input, 1 bit: parallel load strobe.
- `load_val` input, W bits: value loaded when `load`=1.
- `en` input, 1 bit: count enable; also the cascade input.
- `up` input, 1 bit: direction; 1 counts up, 0 counts down.
- `sat_mode` input, 1 bit: 0 = wrap at the boundaries, 1 = saturate at the boundaries.
- `count` output, W bits: current count (registered).
- `epoch` output, EPOCH_W bits: net number of wraps (registered).
- `at_max` output, 1 bit: `count`==N-1 (combinational from register).
- `at_min` output, 1 bit: `count`==0 (combinational from register).
- `carry` output, 1 bit: registered pulse, one per up-wrap.
- `borrow` output, 1 bit: registered pulse, one per down-wrap.
- `sat_hit` output, 1 bit: registered pulse when a step is blocked by saturation.
- `load_err` output, 1 bit: registered pulse when `load_val` ≥ N.
- `cascade_out` output, 1 bit: combinational: `en & (up ? at_max : at_min) & ~sat_mode`.

## Operation
- Priority per cycle, highest first: `arst` > `clr` > `load` > `en` > hold.
- **arst**:
  - `count`=0, `epoch`=0.
  - `carry`, `borrow`, `sat_hit` and `load_err` all 0.
- **clr**:
  - `count`=0; `epoch` is unchanged.
  - All pulse outputs are 0 next cycle.
- **load**:
  - If `load_val` < N: `count`=`load_val`.
  - If `load_val` ≥ N: `count`=N-1 and `load_err`=1 for one cycle.
  - `epoch` is unchanged; no carry or borrow is generated.
- **en, up=1**:
  - If `count` < N-1: `count`+1.
  - If `count`=N-1 and wrap mode: `count`=0, `carry`=1, `epoch`+1 (modulo 2^EPOCH_W).
  - If `count`=N-1 and saturate mode: hold, `sat_hit`=1.
- **en, up=0**:
  - If `count` > 0: `count`-1.
  - If `count`=0 and wrap mode: `count`=N-1, `borrow`=1, `epoch`-1 (modulo 2^EPOCH_W).
  - If `count`=0 and saturate mode: hold, `sat_hit`=1.
- Arithmetic:
  - Next-value is computed in W+1 bits, so N-1+1 never aliases when N=2^W.
  - Down-step from 0 never underflows W bits.
- `en`=0 and no other strobe: all state holds; all pulses are 0.
- Changing `up` or `sat_mode` takes effect on the same edge it is sampled; there is no pipeline.
- Cascade: the next digit's `en` is driven from `cascade_out`. It then steps on the same edge that this digit wraps.

## Timing
- Latency from any strobe to `count`/`epoch` update: 1 cycle.
- Pulse outputs (`carry`, `borrow`, `sat_hit`, `load_err`):
  - Asserted in the cycle the new `count` becomes visible.
  - Exactly one cycle wide per event; back-to-back events give back-to-back pulses.
- `at_max`, `at_min` and `cascade_out` have zero latency relative to `count` and the inputs.
- Reset asserted mid-count (for example at `count`=7, `en`=1): `count`=0 on that edge, and no carry even if `count` was N-1.
- `arst` and `load` on the same edge: `arst` wins.
- `clr` and `load` on the same edge: `clr` wins, and `load_err` is not raised.
- `load` and `en` on the same edge: `load` wins; no step is applied to the loaded value.

## Structure
- Shared package `counter_pkg`:
  - Mode constants `CNT_MODE_WRAP`=0 and `CNT_MODE_SAT`=1.
  - Function `cnt_width(N)` returning max(1, $clog2(N)), used as the default for `W`.
- Sub-module `modn_next_val` (purely combinational):
  - Inputs: `count`, `up`, `sat_mode`.
  - Outputs: next count, wrap_up, wrap_dn, sat.
  - Reused by future multi-channel variants.
- Top level holds the registers, the priority mux, the epoch counter and the pulse registers.

## Test plan
- N=10: reset, then `en`=1, `up`=1 for 12 cycles.
  - `count` goes 0..9, 0, 1.
  - `carry` is high only in the cycle `count`=0 after 9.
  - `epoch`=1.
- N=10: reset, then `en`=1, `up`=0, wrap mode, for 3 cycles.
  - `count` goes 9, 8, 7.
  - `borrow` pulse coincides with `count`=9.
  - `epoch`=255 (EPOCH_W=8).
- N=10, `sat_mode`=1: `load_val`=8, then up for 3 cycles.
  - `count` goes 8, 9, 9, 9.
  - `sat_hit` pulses on the 2nd and 3rd steps.
  - No carry.
- N=10: `load_val`=13.
  - `count`=9, `load_err` is a 1-cycle pulse, `epoch` is unchanged.
  - Next cycle, `load`+`en` asserted with `load_val`=4: `count`=4 (no step applied).
- Two N=10 instances cascaded via `cascade_out` → `en`, counting up from 00 for 100 cycles.
  - The pair reads 99 → 00.
  - The high digit's `carry` fires once.
- `arst` asserted at `count`=9 with `en`=1, `up`=1.
  - `count`=0, `epoch`=0, and no `carry` pulse.
- N=16 (W=4): count up across 15.
  - Wraps to 0 with `carry`, confirming there is no width aliasing.
